// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave port among N_MASTERS requesters.
// Each grant covers exactly one transfer; a watchdog aborts transfers the slave never
// completes and signals the aborted master with a one-cycle error pulse.
module bus_arbiter #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS-1:0]          m_read,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_write_data,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic [DATA_W-1:0]             m_read_data,
    output logic [N_MASTERS-1:0]          m_err,
    output logic                          s_valid,
    output logic                          s_read,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_write_data,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_read_data,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
);

    localparam int unsigned PtrW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    // Counter only ever holds 0..TIMEOUT-1; the +1 view below reaches TIMEOUT.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [PtrW-1:0]        last_ptr_q, last_ptr_d;
    logic [CntW-1:0]        wdog_q, wdog_d;
    logic [N_MASTERS-1:0]   err_q, err_d;

    logic                   pick_any;
    logic [PtrW-1:0]        pick_idx;
    logic [N_MASTERS-1:0]   pick_oh;
    logic [PtrW-1:0]        cand;
    logic [CntW:0]          cnt_now;
    logic                   timeout_hit;

    // Cycle number within the current grant, counting the first GRANT cycle as 1.
    assign cnt_now     = {1'b0, wdog_q} + (CntW + 1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_now == (CntW + 1)'(TIMEOUT));

    // Rotating priority search: first requester after the last winner, wrapping.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = PtrW'((32'(last_ptr_q) + k) % N_MASTERS);
            if (!pick_any && m_valid[cand]) begin
                pick_any      = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, release on completion or watchdog expiry.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        wdog_d     = wdog_q;
        err_d      = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d    = StGrant;
                    grant_d    = pick_oh;
                    last_ptr_d = pick_idx;
                    wdog_d     = '0;
                end
            end
            StGrant: begin
                // Completion wins over a coincident timeout.
                if (s_ready) begin
                    state_d = StIdle;
                    grant_d = '0;
                    wdog_d  = '0;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    wdog_d  = '0;
                    err_d   = grant_q;
                end else if (TIMEOUT != 0) begin
                    wdog_d = cnt_now[CntW-1:0];
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    // State registers; reset leaves the pointer on the last master so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            last_ptr_q <= PtrW'(N_MASTERS - 1);
            wdog_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
        end
    end

    // Forward the granted master's command; everything reads as zero while idle.
    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_addr       = '0;
        s_write_data = '0;
        if (state_q == StGrant) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (grant_q[i]) begin
                    s_read       = s_read | m_read[i];
                    s_write      = s_write | m_write[i];
                    s_addr       = s_addr | m_addr[i*ADDR_W +: ADDR_W];
                    s_write_data = s_write_data | m_write_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign busy        = (state_q == StGrant);
    assign s_valid     = busy;
    assign grant       = grant_q;
    assign m_ready     = grant_q & {N_MASTERS{s_ready & busy}};
    assign m_err       = err_q;
    assign m_read_data = s_read_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_valid;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_write_data;
    logic [N-1:0]      m_ready;
    logic [DW-1:0]     m_read_data;
    logic [N-1:0]      m_err;
    logic              s_valid;
    logic              s_read;
    logic              s_write;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_write_data;
    logic              s_ready;
    logic [DW-1:0]     s_read_data;
    logic [N-1:0]      grant;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_valid      (m_valid),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_addr       (m_addr),
        .m_write_data (m_write_data),
        .m_ready      (m_ready),
        .m_read_data  (m_read_data),
        .m_err        (m_err),
        .s_valid      (s_valid),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_addr       (s_addr),
        .s_write_data (s_write_data),
        .s_ready      (s_ready),
        .s_read_data  (s_read_data),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester strictly after 'last', wrapping; -1 if none.
    function automatic int arb_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Transaction-level model: who owns the bus, for how many cycles, and the pointer.
    int           mo_owner = -1;
    int           mo_last  = N - 1;
    int           mo_age   = 0;
    logic [N-1:0] mo_err   = '0;
    int           waits [N];

    initial begin
        for (int i = 0; i < N; i++) waits[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mo_owner = -1;
                mo_last  = N - 1;
                mo_age   = 0;
                mo_err   = '0;
                for (int i = 0; i < N; i++) waits[i] = 0;
            end else begin
                mo_err = '0;
                if (mo_owner < 0) begin
                    if (m_valid != '0) begin
                        int w;
                        w = arb_pick(m_valid, mo_last);
                        for (int i = 0; i < N; i++) begin
                            if (!m_valid[i] || i == w) begin
                                waits[i] = 0;
                            end else begin
                                waits[i] = waits[i] + 1;
                                n_checks++;
                                if (waits[i] > N - 1) begin
                                    n_errors++;
                                    $display("FAIL fairness: master %0d waited %0d grants, limit %0d",
                                             i, waits[i], N - 1);
                                end
                            end
                        end
                        mo_owner = w;
                        mo_last  = w;
                        mo_age   = 1;
                    end
                end else if (s_ready) begin
                    mo_owner = -1;
                end else if (TO != 0 && mo_age >= TO) begin
                    mo_err[mo_owner] = 1'b1;
                    mo_owner = -1;
                end else begin
                    mo_age = mo_age + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                logic [N-1:0]  g_e;
                logic [AW-1:0] a_e;
                logic [DW-1:0] d_e;
                logic          r_e;
                logic          w_e;
                g_e = '0;
                a_e = '0;
                d_e = '0;
                r_e = 1'b0;
                w_e = 1'b0;
                if (mo_owner >= 0) begin
                    g_e[mo_owner] = 1'b1;
                    a_e = m_addr[mo_owner*AW +: AW];
                    d_e = m_write_data[mo_owner*DW +: DW];
                    r_e = m_read[mo_owner];
                    w_e = m_write[mo_owner];
                end
                check("cmp grant", grant, g_e);
                check("cmp busy", busy, mo_owner >= 0);
                check("cmp s_valid", s_valid, mo_owner >= 0);
                check("cmp s_read", s_read, r_e);
                check("cmp s_write", s_write, w_e);
                check("cmp s_addr", s_addr, a_e);
                check("cmp s_write_data", s_write_data, d_e);
                check("cmp m_ready", m_ready, s_ready ? g_e : '0);
                check("cmp m_err", m_err, mo_err);
                check("cmp m_read_data", m_read_data, s_read_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input bit v, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_valid[i]               = v;
        m_read[i]                = rd;
        m_write[i]               = wr;
        m_addr[i*AW +: AW]       = a;
        m_write_data[i*DW +: DW] = d;
    endtask

    logic [N-1:0] prio_exp [5];
    logic [N-1:0] rot_exp  [5];
    logic [N-1:0] done;
    int           thr;

    initial begin
        prio_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_exp  = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rst_n        = 1'b0;
        m_valid      = '0;
        m_read       = '0;
        m_write      = '0;
        m_addr       = '0;
        m_write_data = '0;
        s_ready      = 1'b0;
        s_read_data  = '0;
        thr          = 4;

        repeat (3) step();
        check("reset grant", grant, 4'b0000);
        check("reset busy", busy, 1'b0);
        check("reset s_valid", s_valid, 1'b0);
        check("reset s_addr", s_addr, 16'h0000);
        check("reset m_err", m_err, 4'b0000);
        check("reset m_ready", m_ready, 4'b0000);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Single master read.
        step();
        set_master(2, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0);
        step();
        #1;
        check("single grant", grant, 4'b0100);
        check("single s_valid", s_valid, 1'b1);
        check("single s_addr", s_addr, 16'h0010);
        check("single s_read", s_read, 1'b1);
        check("single m_ready early", m_ready, 4'b0000);
        step();
        s_ready     = 1'b1;
        s_read_data = 32'hDEADBEEF;
        #1;
        check("single m_ready", m_ready, 4'b0100);
        check("single m_read_data", m_read_data, 32'hDEADBEEF);
        step();
        set_master(2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ready = 1'b0;
        #1;
        check("single bubble busy", busy, 1'b0);
        check("single bubble grant", grant, 4'b0000);
        step();
        #1;
        check("single stays idle", busy, 1'b0);

        // Initial priority after reset, always-ready slave.
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        s_ready = 1'b1;
        for (int i = 0; i < N; i++) set_master(i, 1'b1, 1'b1, 1'b0, AW'(16'h100 + i), 32'h0);
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            if (k % 2 == 0) begin
                check("prio grant", grant, prio_exp[k/2]);
                check("prio m_ready", m_ready, prio_exp[k/2]);
            end else begin
                check("prio gap", grant, 4'b0000);
            end
        end
        m_valid = '0;

        // Rotation: 1 and 3 continuous, 0 once.
        step();
        m_valid = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            if (k % 2 == 0) check("rot grant", grant, rot_exp[k/2]);
            if (m_ready[0]) m_valid[0] = 1'b0;
        end
        m_valid = '0;
        s_ready = 1'b0;

        // Timeout: master 1 write never acknowledged, master 2 waiting behind it.
        step();
        set_master(1, 1'b1, 1'b0, 1'b1, 16'h00A0, 32'hCAFEF00D);
        set_master(2, 1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
        for (int k = 0; k < TO; k++) begin
            step();
            #1;
            check("tmo s_valid", s_valid, 1'b1);
            check("tmo grant", grant, 4'b0010);
            check("tmo s_write_data", s_write_data, 32'hCAFEF00D);
            check("tmo s_addr", s_addr, 16'h00A0);
            check("tmo no err", m_err, 4'b0000);
        end
        step();
        set_master(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        check("tmo s_valid drop", s_valid, 1'b0);
        check("tmo m_err pulse", m_err, 4'b0010);
        step();
        #1;
        check("tmo next grant", grant, 4'b0100);
        check("tmo err cleared", m_err, 4'b0000);
        s_ready = 1'b1;
        #1;
        check("tmo next m_ready", m_ready, 4'b0100);
        step();
        set_master(2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ready = 1'b0;

        // Timeout tie: ready arrives on the TIMEOUT-th grant cycle.
        set_master(3, 1'b1, 1'b1, 1'b0, 16'h0300, 32'h0);
        step();
        #1;
        check("tie grant", grant, 4'b1000);
        for (int k = 1; k < TO; k++) step();
        s_ready = 1'b1;
        #1;
        check("tie m_ready", m_ready, 4'b1000);
        step();
        set_master(3, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_ready = 1'b0;
        #1;
        check("tie no err", m_err, 4'b0000);
        check("tie idle", busy, 1'b0);

        // Reset in the middle of a grant.
        set_master(2, 1'b1, 1'b1, 1'b0, 16'h0222, 32'h0);
        step();
        check("rst pre grant", grant, 4'b0100);
        set_master(0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0);
        set_master(1, 1'b1, 1'b1, 1'b0, 16'h0111, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst s_valid", s_valid, 1'b0);
        check("rst grant", grant, 4'b0000);
        check("rst busy", busy, 1'b0);
        check("rst m_err", m_err, 4'b0000);
        step();
        rst_n = 1'b1;
        step();
        #1;
        check("rst priority", grant, 4'b0001);
        s_ready = 1'b1;
        step();
        m_valid = '0;
        s_ready = 1'b0;
        step();

        // Randomized traffic; requests held until completed or aborted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            done = m_ready | m_err;
            @(posedge clk);
            #1;
            if (c % 500 == 0) thr = $urandom_range(0, 8);
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    m_valid[i] = 1'b0;
                end else if (!m_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_master(i, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               AW'($urandom), $urandom);
                end else if (m_valid[i] && $urandom_range(0, 63) == 0) begin
                    m_valid[i] = 1'b0;
                end
            end
            s_ready     = ($urandom_range(0, 7) < thr);
            s_read_data = $urandom;
        end
        m_valid = '0;
        s_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
